// File: rtl/signed_stream_accumulator.sv
// Accumulates framed W-bit two's-complement samples and emits one result per frame
// (sum, sticky signed-overflow flag, saturating beat count).
//
// state | meaning
// ACCUM | accepting samples into the running sum
// DONE  | frame result presented, waiting for downstream handshake
module signed_stream_accumulator #(
   parameter int W        = 4,
   parameter int CNT_W    = 4,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_sum,
   output logic             out_overflow,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

   localparam logic [W-1:0]     MAX_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]     MIN_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state, state_nxt;
   logic [W-1:0]       acc, raw, acc_upd;
   logic               ovf_sticky, step_ovf;
   logic [CNT_W-1:0]   cnt, cnt_upd;
   logic               beat_acc;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   assign beat_acc = in_valid & in_ready;

   // Overflow only when both operands share a sign and the truncated sum's sign differs.
   always_comb begin
      raw      = acc + in_data;
      step_ovf = (acc[W-1] == in_data[W-1]) && (raw[W-1] != acc[W-1]);
      acc_upd  = raw;
      if (SATURATE != 0 && step_ovf) acc_upd = acc[W-1] ? MIN_NEG : MAX_POS;
      cnt_upd  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ACCUM;
         acc          <= '0;
         ovf_sticky   <= 1'b0;
         cnt          <= '0;
         out_sum      <= '0;
         out_overflow <= 1'b0;
         out_count    <= '0;
      end else begin
         state <= state_nxt;
         if (beat_acc) begin
            if (in_last) begin
               out_sum      <= acc_upd;
               out_overflow <= ovf_sticky | step_ovf;
               out_count    <= cnt_upd;
               acc          <= '0;
               ovf_sticky   <= 1'b0;
               cnt          <= '0;
            end else begin
               acc          <= acc_upd;
               ovf_sticky   <= ovf_sticky | step_ovf;
               cnt          <= cnt_upd;
            end
         end
      end
   end

endmodule

// File: tb/tb_signed_stream_accumulator.sv
// Drives a wrapping and a saturating accumulator with identical framed streams and
// checks both against integer-arithmetic reference sums.
module tb_signed_stream_accumulator;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_last, out_ready;
   logic [3:0] in_data;
   logic in_ready_w, out_valid_w, ovf_w;
   logic in_ready_s, out_valid_s, ovf_s;
   logic [3:0] sum_w, cnt_w, sum_s, cnt_s;

   int vectors = 0;
   int miscompares = 0;

   int acc_w, acc_s, nbeats;
   bit ov_w, ov_s;

   always #5 clk = ~clk;

   signed_stream_accumulator #(.W(4), .CNT_W(4), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_w),
      .out_ready(out_ready), .out_sum(sum_w), .out_overflow(ovf_w), .out_count(cnt_w));

   signed_stream_accumulator #(.W(4), .CNT_W(4), .SATURATE(1)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_sum(sum_s), .out_overflow(ovf_s), .out_count(cnt_s));

   function automatic int wrap4(int v);
      int r;
      r = ((v % 16) + 16) % 16;
      if (r > 7) r -= 16;
      return r;
   endfunction

   function automatic int clamp4(int v);
      if (v > 7) return 7;
      if (v < -8) return -8;
      return v;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      acc_w = 0; acc_s = 0; nbeats = 0; ov_w = 0; ov_s = 0;
   endtask

   task automatic model_beat(int d);
      int t;
      t = acc_w + d;
      if (t > 7 || t < -8) ov_w = 1;
      acc_w = wrap4(t);
      t = acc_s + d;
      if (t > 7 || t < -8) ov_s = 1;
      acc_s = clamp4(t);
      nbeats++;
   endtask

   task automatic beat(int d, bit last);
      chk("in_ready_w", 32'(in_ready_w), 32'd1);
      chk("in_ready_s", 32'(in_ready_s), 32'd1);
      in_valid = 1'b1;
      in_data  = 4'(d);
      in_last  = last;
      model_beat(d);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      in_last  = 1'($urandom);
   endtask

   task automatic idle(int k);
      repeat (k) begin
         in_valid = 1'b0;
         in_data  = 4'($urandom);
         in_last  = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic check_result();
      int ecnt;
      ecnt = (nbeats > 15) ? 15 : nbeats;
      chk("out_valid_w", 32'(out_valid_w), 32'd1);
      chk("out_valid_s", 32'(out_valid_s), 32'd1);
      chk("in_ready_done", 32'({in_ready_w, in_ready_s}), 32'd0);
      chk("sum_w", 32'(sum_w), 32'(acc_w & 15));
      chk("sum_s", 32'(sum_s), 32'(acc_s & 15));
      chk("ovf_w", 32'(ovf_w), 32'(ov_w));
      chk("ovf_s", 32'(ovf_s), 32'(ov_s));
      chk("cnt_w", 32'(cnt_w), 32'(ecnt));
      chk("cnt_s", 32'(cnt_s), 32'(ecnt));
   endtask

   // Hold the result for 'stall' cycles with junk on the input side, then hand it off.
   task automatic handshake(int stall);
      repeat (stall) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom);
         in_data   = 4'($urandom);
         in_last   = 1'($urandom);
         @(negedge clk);
         check_result();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after_hs", 32'({out_valid_w, out_valid_s}), 32'd0);
      chk("in_ready_after_hs", 32'({in_ready_w, in_ready_s}), 32'd3);
      model_clear();
   endtask

   task automatic run_frame(int d0, int d1, int d2, int len);
      int d[3];
      d[0] = d0; d[1] = d1; d[2] = d2;
      for (int i = 0; i < len; i++) beat(d[i], i == len - 1);
      check_result();
      handshake(1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'({out_valid_w, out_valid_s}), 32'd0);
      chk("rst_in_ready", 32'({in_ready_w, in_ready_s}), 32'd3);
      chk("rst_sum", 32'({sum_w, sum_s}), 32'd0);
      chk("rst_ovf", 32'({ovf_w, ovf_s}), 32'd0);
      chk("rst_cnt", 32'({cnt_w, cnt_s}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_frame(1, 2, -1, 3);
      run_frame(7, 1, -3, 3);
      run_frame(4, 7, 0, 2);
      run_frame(-4, -7, 0, 2);
      run_frame(-4, 4, 0, 2);
      run_frame(-6, 0, 0, 1);

      // Long backpressure with in_valid asserted, then next frame starts right after handoff
      beat(3, 1'b0);
      idle(2);
      beat(-2, 1'b1);
      check_result();
      repeat (3) begin
         in_valid = 1'b1; in_data = 4'd5; in_last = 1'b1; out_ready = 1'b0;
         @(negedge clk);
         check_result();
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_out_valid", 32'({out_valid_w, out_valid_s}), 32'd0);
      chk("bp_in_ready", 32'({in_ready_w, in_ready_s}), 32'd3);
      model_clear();
      beat(5, 1'b1);
      check_result();
      handshake(0);

      // Asynchronous reset mid-frame discards the partial sum
      beat(3, 1'b0);
      beat(3, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'({out_valid_w, out_valid_s}), 32'd0);
      chk("arst_in_ready", 32'({in_ready_w, in_ready_s}), 32'd3);
      chk("arst_sum", 32'({sum_w, sum_s}), 32'd0);
      #1 rst = 1'b0;
      model_clear();
      @(negedge clk);
      beat(1, 1'b1);
      check_result();
      handshake(0);

      for (int i = 0; i < 17; i++) beat(0, i == 16);
      check_result();
      chk("cnt_sat_const", 32'(cnt_w), 32'd15);
      handshake(2);

      for (int f = 0; f < 30; f++) begin
         int len;
         len = int'($urandom_range(1, 20));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            beat(int'($urandom_range(0, 15)) - 8, i == len - 1);
         end
         check_result();
         handshake(int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
